random_range_sampler: RTL and testbench
=======================================

# random_range_sampler

Converts the free-running 11-bit pseudo-random state into a bounded random value in `[0, limit)` for the maze generator, which uses it to pick neighbour directions and cell indices. Sits directly downstream of the PRNG. It samples the PRNG output on every cycle, rejects out-of-range candidates, and returns each accepted value to the requester through a request / valid-ready handshake.

## Interface
- `RESULT_WIDTH`, default 5: width of `limit` and `result`; must be 1..11.
- `MAX_TRIES`, default 16: rejected candidates allowed before the fallback fold; must be ≥1.
- `clock`  input  1  rising-edge clock shared with the PRNG.
- `reset`  input  1  asynchronous, active-low reset.
- `lfsr_value`  input  11  current PRNG state, sampled every cycle in SAMPLE.
- `request`  input  1  start a draw; sampled only in IDLE.
- `limit`  input  RESULT_WIDTH  exclusive upper bound; latched with `request`.
- `busy`  output  1  high whenever state ≠ IDLE.
- `valid`  output  1  `result` is held and ready for collection.
- `ready`  input  1  consumer accepts `result` while `valid` is high.
- `result`  output  RESULT_WIDTH  drawn value, always < latched limit.
- `range_error`  output  1  qualifies `valid`; the latched limit was 0.

## Operation
- **FSM states:** IDLE, SAMPLE, DONE.
- **IDLE:**
  - On `request`=1, latch `limit` into `lim_q`, compute `mask_q`, clear `tries`, then go to SAMPLE.
  - `mask_q` is the smallest 2^k−1 ≥ `lim_q`−1, with k=0 giving mask 0.
- **SAMPLE, each cycle:**
  - `cand` = `lfsr_value[RESULT_WIDTH-1:0]` & `mask_q`.
  - If `cand` < `lim_q`: register `result`=`cand` and go to DONE.
  - Else if `tries` = MAX_TRIES−1: register `result` = `cand` − `lim_q` and go to DONE. This is the fallback fold; it is always in range because `mask_q` ≤ 2·`lim_q`−2.
  - Else increment `tries` and stay in SAMPLE.
- **Zero limit:** if `lim_q` = 0, SAMPLE goes straight to DONE with `result`=0 and `range_error`=1.
- **DONE:**
  - `valid`=1; `result` and `range_error` stay stable.
  - On `valid`&`ready`, go to IDLE.
  - `request` is ignored in SAMPLE and DONE.
- **Input stability:** `limit` is not sampled after the latch cycle, so changes to it mid-draw have no effect.
- **Arithmetic:**
  - All comparisons are unsigned, RESULT_WIDTH bits wide.
  - The `tries` counter is $clog2(MAX_TRIES)+1 bits wide and never wraps.
- **Reset:** `reset`=0 at any time, including mid-draw, forces IDLE and clears `tries`, `lim_q` and `mask_q`.
  - Outputs become `busy`=0, `valid`=0, `result`=0, `range_error`=0.
  - No draw is resumed after reset is released.

## Timing
- **Request to result:**
  - `request` is seen in IDLE at edge N.
  - The first candidate is taken from `lfsr_value` during cycle N+1.
  - On acceptance, `valid` is high from edge N+2.
- **Latency:** minimum 2 cycles; maximum MAX_TRIES+1 cycles (fold on the last try).
- **Completion:**
  - `valid` drops on the edge after the cycle where `valid`&`ready`.
  - `ready` held high gives a DONE residency of 1 cycle.
- **Throughput:** with `request` held and `ready` high, one draw per 3 cycles minimum.
- **Busy:** `busy` rises on the edge after the `request` is accepted and falls together with `valid`.
- **Registered outputs:** all outputs come directly from registers, with no combinational path from inputs.

## Configuration
- `SAMPLER_STATS_EN` defined:
  - Adds output `reject_total` [7:0], a saturating count of rejected candidates since reset.
  - Saturates at 255.
  - Fallback folds are not counted as rejects.
  - Reset value is 0.
- `SAMPLER_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- **Direct accept:** `limit`=5, `lfsr_value`=0x003 held, `ready`=1 → `valid` at N+2 with `result`=3; `busy` is high for 3 cycles.
- **Reject then accept:** `limit`=5 (mask 7), `lfsr_value` = 0x007, then 0x006, then 0x002 → `result`=2 at N+4. With SAMPLER_STATS_EN, `reject_total`=2.
- **Fallback fold:** `limit`=5, `lfsr_value`=0x007 held, MAX_TRIES=16 → `valid` at N+17 with `result`=2; `reject_total`=15.
- **Zero and one limits:**
  - `limit`=0 → `valid`, `range_error`=1, `result`=0 at N+2.
  - `limit`=1 with any `lfsr_value` → `result`=0 and `range_error`=0.
- **Back-pressure and ignored request:** `ready`=0 for 10 cycles with `request` pulsing → `valid` and `result` stay stable and no new draw starts. After `ready`=1, `valid` falls and the next `request` is accepted in IDLE.
- **Reset mid-draw:** `reset`=0 asserted in SAMPLE (between clock edges) → `busy`, `valid` and `result` are 0 immediately. After release, a `request` with `limit`=3 and `lfsr_value`=0x001 gives `result`=1.

Source files
------------

// File: rtl/random_range_sampler.sv
// random_range_sampler: turns the free-running 11-bit PRNG state into a
// bounded value in [0, limit) using rejection sampling with a fallback fold
// after MAX_TRIES candidates.
// The PRNG output is registered before it is judged, so the first candidate
// is the value present in the cycle right after the request is accepted.
// Optional feature: define SAMPLER_STATS_EN to add the reject_total counter.
module random_range_sampler #(
   parameter int RESULT_WIDTH = 5,
   parameter int MAX_TRIES    = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [10:0]             lfsr_value,
   input  logic                    request,
   input  logic [RESULT_WIDTH-1:0] limit,
   output logic                    busy,
   output logic                    valid,
   input  logic                    ready,
   output logic [RESULT_WIDTH-1:0] result,
   output logic                    range_error
`ifdef SAMPLER_STATS_EN
   ,
   output logic [7:0]              reject_total
`endif
);

   localparam int TRIES_W = $clog2(MAX_TRIES) + 1;
   localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SAMPLE,
      S_DONE
   } state_e;

   state_e                  state_q, state_d;
   logic [RESULT_WIDTH-1:0] lim_q, lim_d;
   logic [RESULT_WIDTH-1:0] mask_q, mask_d;
   logic [TRIES_W-1:0]      tries_q, tries_d;
   logic                    first_q, first_d;
   logic [RESULT_WIDTH-1:0] samp_q, samp_d;
   logic [RESULT_WIDTH-1:0] result_q, result_d;
   logic                    err_q, err_d;
   logic                    valid_q, valid_d;
   logic                    busy_q, busy_d;
   logic [RESULT_WIDTH-1:0] cand;
`ifdef SAMPLER_STATS_EN
   logic [7:0]              rej_q, rej_d;
`endif

   // Only the low RESULT_WIDTH bits of the PRNG state are ever used.
   if (RESULT_WIDTH < 11) begin : g_unused
      logic unused_lfsr_bits;
      assign unused_lfsr_bits = ^lfsr_value[10:RESULT_WIDTH];
   end

   // Smallest 2^k-1 covering lim-1: smear the top set bit of lim-1 downwards.
   function automatic logic [RESULT_WIDTH-1:0] mask_for(input logic [RESULT_WIDTH-1:0] lim);
      logic [RESULT_WIDTH-1:0] m;
      m = lim - RESULT_WIDTH'(1);
      for (int i = 1; i < RESULT_WIDTH; i++) begin
         m = m | (m >> i);
      end
      if (lim == '0) begin
         m = '0;
      end
      return m;
   endfunction

   // Next-state, datapath and output-register update for the draw FSM.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
      state_d  = state_q;
      lim_d    = lim_q;
      mask_d   = mask_q;
      tries_d  = tries_q;
      first_d  = 1'b0;
      samp_d   = lfsr_value[RESULT_WIDTH-1:0];
      result_d = result_q;
      err_d    = err_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
`ifdef SAMPLER_STATS_EN
      rej_d    = rej_q;
`endif
      cand     = samp_q & mask_q;

      case (state_q)
         S_IDLE: begin
            if (request) begin
               lim_d   = limit;
               mask_d  = mask_for(limit);
               tries_d = '0;
               first_d = 1'b1;
               busy_d  = 1'b1;
               state_d = S_SAMPLE;
            end
         end

         S_SAMPLE: begin
            // The first SAMPLE cycle only loads samp_q with a fresh candidate.
            if (!first_q) begin
               if (lim_q == '0) begin
                  result_d = '0;
                  err_d    = 1'b1;
                  valid_d  = 1'b1;
                  state_d  = S_DONE;
               end else if (cand < lim_q) begin
                  result_d = cand;
                  err_d    = 1'b0;
                  valid_d  = 1'b1;
                  state_d  = S_DONE;
               end else if (tries_q == LAST_TRY) begin
                  // Fold stays in range since mask <= 2*lim-2.
                  result_d = cand - lim_q;
                  err_d    = 1'b0;
                  valid_d  = 1'b1;
                  state_d  = S_DONE;
               end else begin
                  tries_d = tries_q + TRIES_W'(1);
`ifdef SAMPLER_STATS_EN
                  if (rej_q != 8'hFF) begin
                     rej_d = rej_q + 8'd1;
                  end
`endif
               end
            end
         end

         S_DONE: begin
            if (ready) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: every register here is small control/data state, so all are reset; sequential state uses <= only.
      if (!reset) begin
         state_q  <= S_IDLE;
         lim_q    <= '0;
         mask_q   <= '0;
         tries_q  <= '0;
         first_q  <= 1'b0;
         samp_q   <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
`ifdef SAMPLER_STATS_EN
         rej_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         lim_q    <= lim_d;
         mask_q   <= mask_d;
         tries_q  <= tries_d;
         first_q  <= first_d;
         samp_q   <= samp_d;
         result_q <= result_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
`ifdef SAMPLER_STATS_EN
         rej_q    <= rej_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign valid       = valid_q;
   assign result      = result_q;
   assign range_error = err_q;
`ifdef SAMPLER_STATS_EN
   assign reject_total = rej_q;
`endif

endmodule

// File: tb/tb_random_range_sampler.sv
// Self-checking bench for random_range_sampler: a table of directed draws,
// reset and back-pressure sequences, then randomized draws checked against
// an arithmetic reference model of the rejection/fold rules.
module tb_random_range_sampler;

   localparam int RW   = 5;
   localparam int MAXT = 16;
   localparam int SEQN = MAXT + 4;

   logic          clock = 1'b0;
   logic          reset;
   logic [10:0]   lfsr_value;
   logic          request;
   logic [RW-1:0] limit;
   logic          busy;
   logic          valid;
   logic          ready;
   logic [RW-1:0] result;
   logic          range_error;
`ifdef SAMPLER_STATS_EN
   logic [7:0]    reject_total;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int rej_exp  = 0;

   logic [10:0] seq_a [SEQN];

   random_range_sampler #(.RESULT_WIDTH(RW), .MAX_TRIES(MAXT)) dut (
      .clock       (clock),
      .reset       (reset),
      .lfsr_value  (lfsr_value),
      .request     (request),
      .limit       (limit),
      .busy        (busy),
      .valid       (valid),
      .ready       (ready),
      .result      (result),
      .range_error (range_error)
`ifdef SAMPLER_STATS_EN
      ,
      .reject_total(reject_total)
`endif
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic fill_seq(input int l0, input int l1, input int l2, input int lh);
      seq_a[0] = 11'(l0);
      seq_a[1] = 11'(l1);
      seq_a[2] = 11'(l2);
      for (int i = 3; i < SEQN; i++) seq_a[i] = 11'(lh);
   endtask

   // Reference model: rejection sampling described in plain arithmetic.
   // Latency is counted in clock edges from the accepting edge to valid.
   task automatic model(input int lim, output int res, output int err,
                        output int lat, output int rej);
      int m;
      int c;
      res = 0; err = 0; lat = 2; rej = 0;
      if (lim == 0) begin
         err = 1;
         return;
      end
      m = 0;
      while (m < lim - 1) m = 2 * m + 1;
      for (int i = 0; i < MAXT; i++) begin
         c = int'(seq_a[i]) & m;
         if (c < lim) begin
            res = c; lat = i + 2;
            return;
         end
         if (i == MAXT - 1) begin
            res = c - lim; lat = MAXT + 1;
            return;
         end
         rej++;
      end
   endtask

   // One complete draw: request, feed seq_a cycle by cycle, check result,
   // hold ready low for 'hold' cycles while pulsing request, then collect.
   task automatic do_draw(input string name, input int lim, input int hold,
                          input int exp_res, input int exp_err, input int exp_lat,
                          input int exp_rej);
      int  n;
      bit  got;
      @(negedge clock);
      request    = 1'b1;
      limit      = RW'(lim);
      ready      = (hold == 0);
      lfsr_value = 11'($urandom);
      @(negedge clock);
      request    = 1'b0;
      limit      = RW'($urandom);
      lfsr_value = seq_a[0];
      check({name, "_busy_rise"}, int'(busy), 1);
      n = 0; got = 0;
      while (n < 40 && !got) begin
         @(negedge clock);
         n++;
         if (valid) got = 1;
         else lfsr_value = seq_a[(n < SEQN) ? n : SEQN - 1];
      end
      check({name, "_latency"}, got ? n : -1, exp_lat);
      check({name, "_result"}, int'(result), exp_res);
      check({name, "_range_error"}, int'(range_error), exp_err);
      check({name, "_busy_done"}, int'(busy), 1);
      rej_exp = (rej_exp + exp_rej > 255) ? 255 : rej_exp + exp_rej;
`ifdef SAMPLER_STATS_EN
      check({name, "_reject_total"}, int'(reject_total), rej_exp);
`endif
      for (int h = 0; h < hold; h++) begin
         request    = h[0];
         lfsr_value = 11'($urandom);
         limit      = RW'($urandom);
         @(negedge clock);
         check({name, "_hold_valid"}, int'(valid), 1);
         check({name, "_hold_result"}, int'(result), exp_res);
      end
      request = 1'b0;
      ready   = 1'b1;
      @(negedge clock);
      check({name, "_valid_fall"}, int'(valid), 0);
      check({name, "_busy_fall"}, int'(busy), 0);
      @(negedge clock);
      check({name, "_no_new_draw"}, int'(busy), 0);
      ready = 1'b0;
   endtask

   typedef struct {
      string name;
      int lim;
      int l0, l1, l2, lh;
      int hold;
      int exp_res, exp_err, exp_lat, exp_rej;
   } vec_t;

   initial begin
      vec_t vecs [12];
      int r_res, r_err, r_lat, r_rej;
      int lim;

      vecs[0]  = '{"direct",    5, 'h003, 'h003, 'h003, 'h003,  0,  3, 0,  2,  0};
      vecs[1]  = '{"reject2",   5, 'h007, 'h006, 'h002, 'h002,  0,  2, 0,  4,  2};
      vecs[2]  = '{"fold5",     5, 'h007, 'h007, 'h007, 'h007,  0,  2, 0, 17, 15};
      vecs[3]  = '{"zero_lim",  0, 'h7FF, 'h7FF, 'h7FF, 'h7FF,  0,  0, 1,  2,  0};
      vecs[4]  = '{"one_lim",   1, 'h7FF, 'h7FF, 'h7FF, 'h7FF,  0,  0, 0,  2,  0};
      vecs[5]  = '{"lim3",      3, 'h001, 'h001, 'h001, 'h001,  0,  1, 0,  2,  0};
      vecs[6]  = '{"lim4",      4, 'h7FC, 'h7FC, 'h7FC, 'h7FC,  0,  0, 0,  2,  0};
      vecs[7]  = '{"lim16",    16, 'h01F, 'h01F, 'h01F, 'h01F,  0, 15, 0,  2,  0};
      vecs[8]  = '{"lim17",    17, 'h01F, 'h011, 'h010, 'h010,  0, 16, 0,  4,  2};
      vecs[9]  = '{"fold31",   31, 'h3FF, 'h3FF, 'h3FF, 'h3FF,  0,  0, 0, 17, 15};
      vecs[10] = '{"backpress", 6, 'h004, 'h004, 'h004, 'h004, 10,  4, 0,  2,  0};
      vecs[11] = '{"reject_bp", 5, 'h006, 'h005, 'h7FB, 'h7FB,  2,  3, 0,  4,  2};

      reset      = 1'b0;
      request    = 1'b0;
      ready      = 1'b0;
      limit      = '0;
      lfsr_value = '0;

      // Reset state.
      @(negedge clock);
      @(negedge clock);
      check("rst_busy", int'(busy), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_result", int'(result), 0);
      check("rst_range_error", int'(range_error), 0);
`ifdef SAMPLER_STATS_EN
      check("rst_reject_total", int'(reject_total), 0);
`endif
      reset = 1'b1;
      @(negedge clock);

      // Directed table.
      for (int v = 0; v < 12; v++) begin
         fill_seq(vecs[v].l0, vecs[v].l1, vecs[v].l2, vecs[v].lh);
         do_draw(vecs[v].name, vecs[v].lim, vecs[v].hold, vecs[v].exp_res,
                 vecs[v].exp_err, vecs[v].exp_lat, vecs[v].exp_rej);
      end

      // Reset mid-draw: leave result at 3, start a rejecting draw, reset in SAMPLE.
      fill_seq('h003, 'h003, 'h003, 'h003);
      do_draw("pre_reset", 5, 0, 3, 0, 2, 0);
      @(negedge clock);
      request = 1'b1;
      limit   = 5;
      @(negedge clock);
      request    = 1'b0;
      lfsr_value = 11'h007;
      @(negedge clock);
      @(negedge clock);
      check("mid_busy_before_reset", int'(busy), 1);
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_valid", int'(valid), 0);
      check("mid_rst_result", int'(result), 0);
      check("mid_rst_range_error", int'(range_error), 0);
      rej_exp = 0;
`ifdef SAMPLER_STATS_EN
      check("mid_rst_reject_total", int'(reject_total), 0);
`endif
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check("no_resume_busy", int'(busy), 0);
      check("no_resume_valid", int'(valid), 0);
      fill_seq('h001, 'h001, 'h001, 'h001);
      do_draw("after_reset", 3, 0, 1, 0, 2, 0);

      // Randomized draws against the reference model.
      for (int t = 0; t < 40; t++) begin
         lim = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
         if ($urandom_range(0, 3) == 0) begin
            for (int i = 0; i < SEQN; i++) seq_a[i] = 11'($urandom) | 11'h01F;
         end else begin
            for (int i = 0; i < SEQN; i++) seq_a[i] = 11'($urandom);
         end
         model(lim, r_res, r_err, r_lat, r_rej);
         do_draw($sformatf("rand%0d", t), lim, int'($urandom_range(0, 3)),
                 r_res, r_err, r_lat, r_rej);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
